// File: rtl/mult_result_tx.sv
// mult_result_tx: serialises each multiplier product over an SPI mode-0 link.
// A done strobe in IDLE captures res and starts a frame of 2*WIDTH bits, MSB
// first, with CLK_DIV clk cycles per SCLK half-period. A done strobe that
// arrives mid-frame is dropped and latched in the sticky overrun flag.
module mult_result_tx #(
  parameter int WIDTH   = 4,
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] res,
  input  logic               done,
  input  logic               clr_ovr,
  output logic               sclk,
  output logic               cs_n,
  output logic               mosi,
  output logic               busy,
  output logic               tx_done,
  output logic               overrun
);

  localparam int RW    = 2 * WIDTH;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(RW);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(RW - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q;
  logic [RW-1:0]     sr_q;
  logic [DIV_W-1:0]  div_q;
  logic [BIT_W-1:0]  bit_q;
  logic              sclk_q;
  logic              cs_n_q;
  logic              busy_q;
  logic              tx_done_q;
  logic              overrun_q;

  logic              div_end;
  logic              last_bit;
  logic              ovr_evt;
  logic              overrun_d;
  logic [RW-1:0]     sr_shift_d;

  // Half-period / last-bit detection, overrun next state and the shifted word.
  always_comb begin
    div_end    = (div_q == DIV_LAST);
    last_bit   = (bit_q == BIT_LAST);
    // A strobe in IDLE (including the tx_done cycle) is a new frame, not a drop.
    ovr_evt    = done && (state_q == SHIFT);
    // A new drop wins over a simultaneous clear.
    overrun_d  = ovr_evt || (overrun_q && !clr_ovr);
    sr_shift_d = {sr_q[RW-2:0], 1'b0};
  end

  // Frame FSM: divider, SCLK generation, shifting, framing and the overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      overrun_q <= overrun_d;
      case (state_q)
        IDLE: begin
          if (done) begin
            state_q <= SHIFT;
            sr_q    <= res;
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q <= '0;
            if (!sclk_q) begin
              // Rising edge: data holds so the receiver samples a settled bit.
              sclk_q <= 1'b1;
            end else if (last_bit) begin
              // Final falling edge closes the frame; clearing sr_q idles mosi low.
              state_q   <= IDLE;
              sclk_q    <= 1'b0;
              cs_n_q    <= 1'b1;
              busy_q    <= 1'b0;
              tx_done_q <= 1'b1;
              sr_q      <= '0;
            end else begin
              sclk_q <= 1'b0;
              sr_q   <= sr_shift_d;
              bit_q  <= bit_q + BIT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // mosi is the MSB of the shift register, so it moves only when sr_q does.
  assign mosi    = sr_q[RW-1];
  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_mult_result_tx.sv
// Bench for mult_result_tx: one instance with CLK_DIV=2 and one with CLK_DIV=1.
// A monitor collects each frame (bits at sclk rises, cs_n low length, tx_done
// pulses, mosi stability); each test task compares against values derived from
// the product value and the frame-timing rules.
module tb_mult_result_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       done0, done1, clr_ovr;
  logic [7:0] res;
  logic sclk0, cs_n0, mosi0, busy0, txd0, ovr0;
  logic sclk1, cs_n1, mosi1, busy1, txd1, ovr1;

  mult_result_tx #(.WIDTH(4), .CLK_DIV(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .res(res), .done(done0), .clr_ovr(clr_ovr),
    .sclk(sclk0), .cs_n(cs_n0), .mosi(mosi0), .busy(busy0),
    .tx_done(txd0), .overrun(ovr0)
  );

  mult_result_tx #(.WIDTH(4), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .res(res), .done(done1), .clr_ovr(clr_ovr),
    .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .busy(busy1),
    .tx_done(txd1), .overrun(ovr1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit sel = 1'b0;

  logic m_sclk, m_cs, m_mosi, m_busy, m_txd, m_ovr;
  always_comb begin
    if (sel) begin
      m_sclk = sclk1; m_cs = cs_n1; m_mosi = mosi1;
      m_busy = busy1; m_txd = txd1; m_ovr = ovr1;
    end else begin
      m_sclk = sclk0; m_cs = cs_n0; m_mosi = mosi0;
      m_busy = busy0; m_txd = txd0; m_ovr = ovr0;
    end
  end

  task automatic drive_done(input bit v);
    if (sel) done1 = v;
    else     done0 = v;
  endtask

  // Pulse done for one posedge; returns on the negedge just after acceptance.
  task automatic pulse_done(input logic [7:0] v);
    @(negedge clk);
    res = v;
    drive_done(1'b1);
    @(negedge clk);
    drive_done(1'b0);
    res = 8'($urandom);
  endtask

  // Observe a frame starting at the current negedge until cs_n rises.
  task automatic mon(input int inj_at, input logic [7:0] inj_v,
                     input bit b2b, input logic [7:0] b2b_v,
                     output logic [7:0] bits, output int nrise, output int lowcyc,
                     output int ntxd, output bit edge_ok, output bit stab_ok,
                     output bit to);
    logic ms [256];
    int   ridx [16];
    logic prev_sclk;
    bit   fin;
    int   cd;
    cd = sel ? 1 : 2;
    bits = 8'h00; nrise = 0; lowcyc = 0; ntxd = 0;
    edge_ok = 1'b1; stab_ok = 1'b1; to = 1'b0; fin = 1'b0;
    prev_sclk = 1'b0;
    if (m_sclk !== 1'b0) edge_ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) begin
        @(negedge clk);
        drive_done(1'b0);
      end
      if (m_txd === 1'b1) ntxd++;
      if (m_cs === 1'b1) begin
        if (m_sclk !== 1'b0) edge_ok = 1'b0;
        if (b2b) begin
          res = b2b_v;
          drive_done(1'b1);
        end
        fin = 1'b1;
        break;
      end
      ms[lowcyc] = m_mosi;
      if (m_sclk === 1'b1 && prev_sclk === 1'b0) begin
        bits = {bits[6:0], m_mosi};
        if (nrise < 16) ridx[nrise] = lowcyc;
        nrise++;
      end
      prev_sclk = m_sclk;
      lowcyc++;
      if (k == inj_at) begin
        res = inj_v;
        drive_done(1'b1);
      end
    end
    if (!fin) to = 1'b1;
    for (int r = 0; r < nrise && r < 16; r++) begin
      for (int j = ridx[r] - cd; j < ridx[r] + cd; j++) begin
        if (j < 0 || j >= lowcyc) stab_ok = 1'b0;
        else if (ms[j] !== ms[ridx[r]]) stab_ok = 1'b0;
      end
    end
  endtask

  logic [7:0] bits;
  int nrise, lowcyc, ntxd;
  bit edge_ok, stab_ok, to;

  task automatic test_reset();
    sel = 1'b0;
    rst_n = 1'b0; done0 = 1'b1; done1 = 1'b1; clr_ovr = 1'b0; res = 8'hE7;
    repeat (3) @(negedge clk);
    n_cmp++; if ({cs_n0, sclk0, mosi0, busy0, txd0, ovr0} !== 6'b100000) begin
      n_bad++; $display("FAIL reset_dut0 got %b want 100000", {cs_n0, sclk0, mosi0, busy0, txd0, ovr0}); end
    n_cmp++; if ({cs_n1, sclk1, mosi1, busy1, txd1, ovr1} !== 6'b100000) begin
      n_bad++; $display("FAIL reset_dut1 got %b want 100000", {cs_n1, sclk1, mosi1, busy1, txd1, ovr1}); end
    // Release with done already high: first posedge out of reset starts a frame.
    rst_n = 1'b1; res = 8'h96;
    @(negedge clk);
    done0 = 1'b0; done1 = 1'b0; res = 8'($urandom);
    n_cmp++; if (cs_n0 !== 1'b0 || busy0 !== 1'b1 || mosi0 !== 1'b1) begin
      n_bad++; $display("FAIL first_accept got cs=%b busy=%b mosi=%b want 0 1 1", cs_n0, busy0, mosi0); end
    mon(-1, 8'h00, 1'b0, 8'h00, bits, nrise, lowcyc, ntxd, edge_ok, stab_ok, to);
    n_cmp++; if (bits !== 8'h96 || ntxd !== 1 || to) begin
      n_bad++; $display("FAIL first_frame got bits=%h txd=%0d to=%0d want 96 1 0", bits, ntxd, to); end
  endtask

  task automatic test_basic();
    sel = 1'b0;
    pulse_done(8'hA5);
    mon(-1, 8'h00, 1'b0, 8'h00, bits, nrise, lowcyc, ntxd, edge_ok, stab_ok, to);
    n_cmp++; if (bits !== 8'hA5) begin n_bad++; $display("FAIL basic_bits got %h want a5", bits); end
    n_cmp++; if (lowcyc !== 32) begin n_bad++; $display("FAIL basic_len got %0d want 32", lowcyc); end
    n_cmp++; if (nrise !== 8 || ntxd !== 1) begin
      n_bad++; $display("FAIL basic_edges got rises=%0d txd=%0d want 8 1", nrise, ntxd); end
    n_cmp++; if (!stab_ok || !edge_ok) begin
      n_bad++; $display("FAIL basic_stable got stab=%0d edge=%0d want 1 1", stab_ok, edge_ok); end
    @(negedge clk);
    n_cmp++; if (txd0 !== 1'b0 || busy0 !== 1'b0 || mosi0 !== 1'b0) begin
      n_bad++; $display("FAIL basic_after got txd=%b busy=%b mosi=%b want 0 0 0", txd0, busy0, mosi0); end
  endtask

  task automatic test_extremes();
    logic [7:0] vals [2];
    vals[0] = 8'h00; vals[1] = 8'hFF;
    sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pulse_done(vals[i]);
      mon(-1, 8'h00, 1'b0, 8'h00, bits, nrise, lowcyc, ntxd, edge_ok, stab_ok, to);
      n_cmp++; if (bits !== vals[i] || nrise !== 8) begin
        n_bad++; $display("FAIL extreme_bits got %h rises=%0d want %h 8", bits, nrise, vals[i]); end
      n_cmp++; if (!edge_ok || lowcyc !== 32) begin
        n_bad++; $display("FAIL extreme_edges got edge=%0d len=%0d want 1 32", edge_ok, lowcyc); end
    end
  endtask

  task automatic test_overrun();
    sel = 1'b0;
    pulse_done(8'h3C);
    mon(5, 8'hFF, 1'b0, 8'h00, bits, nrise, lowcyc, ntxd, edge_ok, stab_ok, to);
    n_cmp++; if (ovr0 !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %b want 1", ovr0); end
    n_cmp++; if (bits !== 8'h3C || lowcyc !== 32 || ntxd !== 1) begin
      n_bad++; $display("FAIL ovr_frame got bits=%h len=%0d txd=%0d want 3c 32 1", bits, lowcyc, ntxd); end
    @(negedge clk);
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL ovr_ignored got busy=%b want 0", busy0); end
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    n_cmp++; if (ovr0 !== 1'b0 || cs_n0 !== 1'b1 || txd0 !== 1'b0) begin
      n_bad++; $display("FAIL ovr_clear got ovr=%b cs=%b txd=%b want 0 1 0", ovr0, cs_n0, txd0); end
    // Clear and a fresh drop in the same cycle: the drop wins.
    pulse_done(8'h4B);
    done0 = 1'b1; clr_ovr = 1'b1;
    @(negedge clk);
    done0 = 1'b0; clr_ovr = 1'b0;
    n_cmp++; if (ovr0 !== 1'b1) begin n_bad++; $display("FAIL ovr_clr_race got %b want 1", ovr0); end
    mon(-1, 8'h00, 1'b0, 8'h00, bits, nrise, lowcyc, ntxd, edge_ok, stab_ok, to);
    n_cmp++; if (bits !== 8'h4B || to) begin
      n_bad++; $display("FAIL ovr_race_frame got bits=%h to=%0d want 4b 0", bits, to); end
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    pulse_done(8'h27);
    mon(-1, 8'h00, 1'b1, 8'h81, bits, nrise, lowcyc, ntxd, edge_ok, stab_ok, to);
    n_cmp++; if (bits !== 8'h27 || ntxd !== 1) begin
      n_bad++; $display("FAIL b2b_first got bits=%h txd=%0d want 27 1", bits, ntxd); end
    @(negedge clk);
    done0 = 1'b0; res = 8'($urandom);
    n_cmp++; if (cs_n0 !== 1'b0 || ovr0 !== 1'b0) begin
      n_bad++; $display("FAIL b2b_gap got cs=%b ovr=%b want 0 0", cs_n0, ovr0); end
    mon(-1, 8'h00, 1'b0, 8'h00, bits, nrise, lowcyc, ntxd, edge_ok, stab_ok, to);
    n_cmp++; if (bits !== 8'h81 || lowcyc !== 32 || nrise !== 8) begin
      n_bad++; $display("FAIL b2b_second got bits=%h len=%0d rises=%0d want 81 32 8", bits, lowcyc, nrise); end
  endtask

  task automatic test_reset_mid();
    int txc;
    sel = 1'b0;
    pulse_done(8'hC3);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if ({cs_n0, sclk0, busy0, txd0, mosi0} !== 5'b10000) begin
      n_bad++; $display("FAIL midrst_state got %b want 10000", {cs_n0, sclk0, busy0, txd0, mosi0}); end
    rst_n = 1'b1;
    txc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (txd0 !== 1'b0 || cs_n0 !== 1'b1) txc++;
    end
    n_cmp++; if (txc !== 0) begin n_bad++; $display("FAIL midrst_quiet got %0d want 0", txc); end
    pulse_done(8'h6E);
    mon(-1, 8'h00, 1'b0, 8'h00, bits, nrise, lowcyc, ntxd, edge_ok, stab_ok, to);
    n_cmp++; if (bits !== 8'h6E || lowcyc !== 32 || ntxd !== 1 || !stab_ok) begin
      n_bad++; $display("FAIL midrst_frame got bits=%h len=%0d txd=%0d stab=%0d want 6e 32 1 1",
                        bits, lowcyc, ntxd, stab_ok); end
  endtask

  task automatic test_clkdiv1();
    sel = 1'b1;
    pulse_done(8'h5A);
    mon(-1, 8'h00, 1'b0, 8'h00, bits, nrise, lowcyc, ntxd, edge_ok, stab_ok, to);
    n_cmp++; if (bits !== 8'h5A || lowcyc !== 16) begin
      n_bad++; $display("FAIL div1_frame got bits=%h len=%0d want 5a 16", bits, lowcyc); end
    n_cmp++; if (nrise !== 8 || ntxd !== 1 || !stab_ok || !edge_ok) begin
      n_bad++; $display("FAIL div1_edges got rises=%0d txd=%0d stab=%0d edge=%0d want 8 1 1 1",
                        nrise, ntxd, stab_ok, edge_ok); end
    sel = 1'b0;
  endtask

  task automatic test_random();
    bit exp_ovr [2];
    logic [7:0] v;
    int inj, len;
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    exp_ovr[0] = 1'b0; exp_ovr[1] = 1'b0;
    for (int it = 0; it < 10; it++) begin
      sel = 1'($urandom);
      len = sel ? 16 : 32;
      v = 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        exp_ovr[0] = 1'b0; exp_ovr[1] = 1'b0;
      end
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 2)) : -1;
      if (inj >= 0) exp_ovr[sel] = 1'b1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_done(v);
      mon(inj, 8'($urandom), 1'b0, 8'h00, bits, nrise, lowcyc, ntxd, edge_ok, stab_ok, to);
      n_cmp++; if (bits !== v || lowcyc !== len || ntxd !== 1 || !stab_ok) begin
        n_bad++; $display("FAIL rand_frame[%0d] got bits=%h len=%0d txd=%0d stab=%0d want %h %0d 1 1",
                          it, bits, lowcyc, ntxd, stab_ok, v, len); end
      n_cmp++; if (m_ovr !== exp_ovr[sel]) begin
        n_bad++; $display("FAIL rand_ovr[%0d] got %b want %b", it, m_ovr, exp_ovr[sel]); end
      // Let the slower instance finish before the next frame on either instance.
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_clkdiv1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_result_tx.md
MULT_RESULT_TX -- requirements
Module: mult_result_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, multiplier operand width; result word is 2*WIDTH bits.
REQ-002 SHALL have parameter CLK_DIV, default 2, clk cycles per SCLK half-period; legal values are 1 and greater.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on the posedge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset; synchronous, active-low.
REQ-005 SHALL have port res, input, 2*WIDTH bits, multiplier product; valid only while done=1.
REQ-006 SHALL have port done, input, 1 bit, one-cycle product-valid strobe from the multiplier.
REQ-007 SHALL have port clr_ovr, input, 1 bit, synchronous clear of the overrun flag.
REQ-008 SHALL have port sclk, output, 1 bit, serial clock; idle low (SPI mode 0).
REQ-009 SHALL have port cs_n, output, 1 bit, chip select; active low.
REQ-010 SHALL have port mosi, output, 1 bit, serial data; MSB first.
REQ-011 SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-012 SHALL have port tx_done, output, 1 bit, one-cycle pulse at the end of each frame.
REQ-013 SHALL have port overrun, output, 1 bit, sticky flag for a dropped product.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (busy=0) and SHIFT (busy=1).
REQ-015 In IDLE, done=1 SHALL on the same edge: capture res into the 2*WIDTH-bit shift register, drive cs_n=0, busy=1, sclk=0, mosi=res[2*WIDTH-1], clear the divider, and clear the bit counter.
REQ-016 In SHIFT, the divider SHALL count CLK_DIV clk cycles per half-period, then toggle sclk.
REQ-017 On each sclk rising toggle, mosi and the shift register SHALL hold (receiver samples here).
REQ-018 On each sclk falling toggle that is not the last, the shift register SHALL shift left by 1, mosi SHALL take the new MSB, and the bit counter SHALL increment.
REQ-019 On the falling toggle after the 2*WIDTH-th rising edge, the block SHALL set sclk=0, cs_n=1, busy=0, mosi=0, and tx_done=1 for exactly that cycle, then return to IDLE.
REQ-020 Frame length (cs_n low) SHALL be exactly 2*WIDTH*2*CLK_DIV clk cycles.
REQ-021 The block SHALL produce exactly 2*WIDTH sclk rising edges per frame; mosi SHALL be stable for CLK_DIV cycles on each side of every rising edge.
REQ-022 done=1 in the same cycle tx_done=1 SHALL be accepted as a new frame: cs_n is high for exactly one cycle between frames.
REQ-023 done=1 while busy=1 (excluding REQ-022) SHALL set overrun=1 and be otherwise ignored; the in-flight frame is unaffected.
REQ-024 overrun SHALL remain set until clr_ovr=1 or reset; if clr_ovr=1 and a new overrun event occur in the same cycle, overrun SHALL be 1.
REQ-025 res SHALL NOT be sampled except on an accepted done.
REQ-026 clr_ovr SHALL have no effect on any output other than overrun.

Reset
REQ-027 While rst_n=0 at a posedge: state=IDLE, sclk=0, cs_n=1, mosi=0, busy=0, tx_done=0, overrun=0, shift register=0, divider=0, bit counter=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no tx_done pulse; done is ignored while rst_n=0.
REQ-029 The first frame SHALL be accepted on the first posedge with rst_n=1 and done=1.

Verification (WIDTH=4, CLK_DIV=2)
REQ-030 Basic frame: res=8'hA5 with done pulsed -> cs_n low for 32 cycles; mosi at the 8 sclk rising edges = 1,0,1,0,0,1,0,1; one tx_done pulse.
REQ-031 Extremes: res=8'h00, then res=8'hFF -> all-0 and all-1 bit streams; 8 rising edges each; sclk low at both cs_n edges.
REQ-032 Overrun: frame of 8'h3C, done pulsed again with res=8'hFF on frame cycle 5 -> overrun=1; bits remain 0,0,1,1,1,1,0,0; clr_ovr pulse -> overrun=0.
REQ-033 Back-to-back: done coincident with tx_done, res=8'h81 -> cs_n high for 1 cycle; second frame transmits 1,0,0,0,0,0,0,1.
REQ-034 Reset mid-frame: rst_n=0 on frame cycle 10 -> next posedge cs_n=1, sclk=0, busy=0, no tx_done; a new done after release -> clean full frame.
REQ-035 CLK_DIV=1: res=8'h5A -> frame of 16 cycles; bits 0,1,0,1,1,0,1,0.
